// File: rtl/uart_pkg.sv
// Shared types and constants for the 96-bit UART transmitter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } uart_tx_state_t;

  localparam int UART_NUM_BYTES       = 12;
  localparam int UART_PAYLOAD_W       = 96;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_96_if.sv
// Handshake/payload bundle between the pulse generator and the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: none; start is a strobe and busy tells the producer it will be ignored.
// Signals: start (strobe), data (96-bit payload), tx (serial line), busy, done (pulse).
interface uart_tx_96_if;
  import uart_pkg::*;

  logic                      start;
  logic [UART_PAYLOAD_W-1:0] data;
  logic                      tx;
  logic                      busy;
  logic                      done;

  // master: the producer side that strobes start and watches status
  modport master (output start, data, input tx, busy, done);
  // slave: the transmitter
  modport slave  (input start, data, output tx, busy, done);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Latency: tick is combinational from the count register.
// Backpressure: none; clear restarts the period from 0 on the next cycle.
// Ports: clk, rst (sync, active-high), clear (restart period), tick (last cycle of period).
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Must not depend on clear: clear is derived from the state change this tick causes.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_96.sv
// Sends a 96-bit payload as 12 back-to-back 8N1 frames, byte 0 (data[7:0]) first, LSB first.
// Latency: tx falls one cycle after start is accepted; done pulses 120*CLKS_PER_BIT+1 cycles after accept.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
// Ports: clk, rst (sync, active-high), bus (slave: start, data in; tx, busy, done out).
module uart_tx_96
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_BYTES    = UART_NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_96_if.slave  bus
);

  localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);

  uart_tx_state_t            state_q, state_d;
  logic [3:0]                byte_cnt_q, byte_cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_PAYLOAD_W-1:0] shreg_q, shreg_d;
  logic                      fin_q, fin_d;
  logic                      tx_q, tx_d;
  logic                      busy_q;
  logic                      done_q;
  logic                      tick;
  logic                      baud_clear;

  // Counter sits at 0 while idle and restarts on every state change, so each
  // state owns exactly one full bit period.
  assign baud_clear = (state_q == IDLE) || (state_d != state_q);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    fin_d      = 1'b0;
    tx_d       = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = START_BIT;
          shreg_d    = bus.data;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START_BIT: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d   = DATA_BITS;
          bit_cnt_d = '0;
        end
      end
      DATA_BITS: begin
        // Current byte always lives in the low 8 bits of the shift register.
        tx_d = shreg_q[bit_cnt_q];
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP_BIT: begin
        if (tick) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = IDLE;
            fin_d   = 1'b1;
          end else begin
            state_d    = START_BIT;
            byte_cnt_d = byte_cnt_q + 4'd1;
            shreg_d    = shreg_q >> 8;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by
  // one cycle; fin_q carries the completion into the same delayed timeline so
  // done and the busy fall land on the edge after the last stop bit ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      fin_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      fin_q      <= fin_d;
      tx_q       <= tx_d;
      busy_q     <= (state_q != IDLE);
      done_q     <= fin_q;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx_96.sv
// Directed/random bench for uart_tx_96 with a timeline-level reference of the serial line.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_tx_96;

  localparam int C    = 4;
  localparam int LAST = 120 * C + 1;  // offset of done after the accepting edge

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] tab [12] = '{8'hDB, 8'h0F, 8'h49, 8'hC0, 8'h00, 8'h00,
                           8'h00, 8'h40, 8'h00, 8'h00, 8'h80, 8'h3F};

  uart_tx_96_if bus ();

  uart_tx_96 #(
    .CLKS_PER_BIT (C),
    .NUM_BYTES    (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected line level j cycles after the accepting edge: 12 frames of
  // start(0), 8 data bits LSB first, stop(1), each bit C cycles; idle high elsewhere.
  function automatic logic exp_line(input logic [95:0] d, input int j);
    int idx, f, p;
    if (j < 1 || j > 120 * C) return 1'b1;
    idx = (j - 1) / C;
    f   = idx / 10;
    p   = idx % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return d[8 * f + p - 1];
  endfunction

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Presents start for one edge; returns at the negedge just after the accept edge.
  task automatic launch(input logic [95:0] d);
    bus.start = 1'b1;
    bus.data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check(tag, 96'(bad), 96'd0);
  endtask

  // Walks the transfer from offset 0 (accept edge) to the done cycle, comparing
  // every cycle against exp_line and decoding frames from mid-bit samples.
  task automatic watch(input logic [95:0] d, input string tag, input int ign_at,
                       input bit scramble, input int stop_at, input bit use_tab);
    int         bad = 0;
    logic       bits [120];
    logic [7:0] by;
    int         framing = 0;
    for (int j = 0; j <= LAST; j++) begin
      if (stop_at > 0 && j >= stop_at) begin
        check({tag, "_wave_partial"}, 96'(bad), 96'd0);
        return;
      end
      if (j > 0) @(negedge clk);
      if (bus.tx   !== exp_line(d, j))               bad++;
      if (bus.busy !== (j >= 1 && j <= 120 * C))     bad++;
      if (bus.done !== (j == LAST))                  bad++;
      if (j >= 1 && j <= 120 * C && ((j - 1) % C) == C / 2) bits[(j - 1) / C] = bus.tx;
      bus.start = (j == ign_at);
      if (j == ign_at) bus.data = '1;
      else if (scramble) bus.data = rnd96();
    end
    check({tag, "_wave"}, 96'(bad), 96'd0);
    for (int f = 0; f < 12; f++) begin
      for (int b = 0; b < 8; b++) by[b] = bits[10 * f + 1 + b];
      if (bits[10 * f] !== 1'b0 || bits[10 * f + 9] !== 1'b1) framing++;
      check($sformatf("%s_byte%0d", tag, f), 96'(by), use_tab ? 96'(tab[f]) : 96'(d[8 * f +: 8]));
    end
    check({tag, "_framing"}, 96'(framing), 96'd0);
  endtask

  initial begin
    logic [95:0] d, d2;
    int          bad;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.data  = '0;
    repeat (3) @(negedge clk);
    check("reset_tx",   96'(bus.tx),   96'd1);
    check("reset_busy", 96'(bus.busy), 96'd0);
    check("reset_done", 96'(bus.done), 96'd0);
    rst = 1'b0;
    idle(50, "reset_idle");

    // Single payload against the literal byte table.
    d = 96'h3F800000_40000000_C0490FDB;
    launch(d);
    watch(d, "single", -1, 1'b0, 0, 1'b1);
    idle(10, "single_after");

    // All-ones start issued mid-transfer must not disturb anything.
    d = rnd96();
    launch(d);
    watch(d, "ignored", 100, 1'b0, 0, 1'b0);
    idle(60, "ignored_one_done");

    // Back-to-back: second start presented in the done cycle.
    d  = rnd96();
    d2 = rnd96();
    launch(d);
    watch(d, "b2b_first", -1, 1'b0, 0, 1'b0);
    launch(d2);
    watch(d2, "b2b_second", -1, 1'b0, 0, 1'b0);
    idle(10, "b2b_after");

    // Reset during byte 5, data bit 3.
    d = rnd96();
    launch(d);
    watch(d, "abort", -1, 1'b0, (5 * 10 + 1 + 3) * C + 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx",   96'(bus.tx),   96'd1);
    check("abort_busy", 96'(bus.busy), 96'd0);
    check("abort_done", 96'(bus.done), 96'd0);
    rst = 1'b0;
    idle(500, "abort_no_done");
    d = rnd96();
    launch(d);
    watch(d, "after_abort", -1, 1'b0, 0, 1'b0);
    idle(5, "after_abort_idle");

    // Data changes every cycle after accept.
    d = rnd96();
    launch(d);
    watch(d, "isolation", -1, 1'b1, 0, 1'b0);
    bus.data = '0;
    idle(5, "isolation_idle");

    // A couple of plain random payloads with random gaps.
    for (int k = 0; k < 2; k++) begin
      d = rnd96();
      launch(d);
      watch(d, $sformatf("rand%0d", k), -1, 1'b0, 0, 1'b0);
      bad = int'($urandom_range(1, 20));
      idle(bad, $sformatf("rand%0d_gap", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
